// File: rtl/shift_cmd_pkg.sv
// Shared definitions for the shifter command issuer: op codes, control
// word layout, FSM state type and command-to-control decode helpers.
package shift_cmd_pkg;

  // Command op codes
  localparam logic [1:0] OP_NOP         = 2'b00;
  localparam logic [1:0] OP_LOAD        = 2'b01;
  localparam logic [1:0] OP_LOAD_DOUBLE = 2'b10;
  localparam logic [1:0] OP_INCREMENT   = 2'b11;

  // Bit positions inside the shifter control word
  localparam int CTRL_EN  = 0;
  localparam int CTRL_DBL = 1;
  localparam int CTRL_OP  = 2;

  // Complete control words driven to the shifter
  localparam logic [2:0] CTRL_IDLE = 3'b000;
  localparam logic [2:0] CTRL_LOAD = 3'b001;
  localparam logic [2:0] CTRL_LDBL = 3'b011;
  localparam logic [2:0] CTRL_INC  = 3'b101;

  // Queued command layout: {op[1:0], data[3:0], repeat[3:0]}
  localparam int CMD_W = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Map an op code to the control word the shifter expects.
  function automatic logic [2:0] ctrl_word(input logic [1:0] op);
    logic [2:0] w;
    case (op)
      OP_NOP:         w = CTRL_IDLE;
      OP_LOAD:        w = CTRL_LOAD;
      OP_LOAD_DOUBLE: w = CTRL_LDBL;
      OP_INCREMENT:   w = CTRL_INC;
      default:        w = CTRL_IDLE;
    endcase
    return w;
  endfunction

  // Operand is only meaningful for the two load variants; zero otherwise.
  function automatic logic [3:0] op_data(input logic [1:0] op, input logic [3:0] data);
    logic [3:0] d;
    case (op)
      OP_LOAD:        d = data;
      OP_LOAD_DOUBLE: d = data;
      default:        d = 4'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Small synchronous command FIFO with first-word-fall-through read data,
// a synchronous clear and an occupancy count.
module shift_cmd_fifo
  import shift_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign level     = count_r;

  // Storage array; contents need no reset because count_r guards reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; clear wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (clear) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/shift_cmd_issuer.sv
// Command issuer for the 4-bit load/double/increment shifter: queues
// commands, replays each as cmd_repeat+1 cycles of control/data_out with
// no bubble between queued commands, and counts enabled shifter cycles.
module shift_cmd_issuer
  import shift_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [3:0]               cmd_data,
  input  logic [3:0]               cmd_repeat,
  input  logic                     flush,
  output logic [2:0]               control,
  output logic [3:0]               data_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         op_count
);

  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CMD_W-1:0] fifo_dout_s;
  logic             push_s;
  logic             pop_s;
  logic [1:0]       head_op_s;
  logic [3:0]       head_data_s;
  logic [3:0]       head_rpt_s;

  state_t           state_r;
  logic [3:0]       rpt_r;
  logic [2:0]       control_r;
  logic [3:0]       data_r;
  logic             busy_r;
  logic [CNT_W-1:0] op_count_r;

  // Full is the registered occupancy, so a same-edge pop never frees a slot early.
  assign cmd_ready   = !fifo_full_s && !flush;
  assign push_s      = cmd_valid && cmd_ready;
  assign head_op_s   = fifo_dout_s[9:8];
  assign head_data_s = fifo_dout_s[7:4];
  assign head_rpt_s  = fifo_dout_s[3:0];

  assign control  = control_r;
  assign data_out = data_r;
  assign busy     = busy_r;
  assign op_count = op_count_r;

  shift_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({cmd_op, cmd_data, cmd_repeat}),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (level)
  );

  // Pop the head when idle, or on the last issue cycle of the current command.
  always_comb begin
    pop_s = 1'b0;
    if (flush || fifo_empty_s) begin
      pop_s = 1'b0;
    end else if (state_r == IDLE) begin
      pop_s = 1'b1;
    end else if (rpt_r == 4'd0) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Issue FSM with registered control, data and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rpt_r     <= 4'd0;
      control_r <= CTRL_IDLE;
      data_r    <= 4'h0;
      busy_r    <= 1'b0;
    end else if (flush) begin
      state_r   <= IDLE;
      rpt_r     <= 4'd0;
      control_r <= CTRL_IDLE;
      data_r    <= 4'h0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r   <= ISSUE;
            rpt_r     <= head_rpt_s;
            control_r <= ctrl_word(head_op_s);
            data_r    <= op_data(head_op_s, head_data_s);
            busy_r    <= 1'b1;
          end else begin
            state_r   <= IDLE;
            rpt_r     <= 4'd0;
            control_r <= CTRL_IDLE;
            data_r    <= 4'h0;
            busy_r    <= 1'b0;
          end
        end
        ISSUE: begin
          if (rpt_r != 4'd0) begin
            rpt_r <= rpt_r - 4'd1;
          end else if (pop_s) begin
            rpt_r     <= head_rpt_s;
            control_r <= ctrl_word(head_op_s);
            data_r    <= op_data(head_op_s, head_data_s);
            busy_r    <= 1'b1;
          end else begin
            state_r   <= IDLE;
            control_r <= CTRL_IDLE;
            data_r    <= 4'h0;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          rpt_r     <= 4'd0;
          control_r <= CTRL_IDLE;
          data_r    <= 4'h0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Count every cycle the shifter is enabled; flush does not disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= CNT_W'(0);
    end else if (control_r[CTRL_EN]) begin
      op_count_r <= op_count_r + CNT_W'(1);
    end else begin
      op_count_r <= op_count_r;
    end
  end

endmodule
